knn_seq_ctrl: RTL

- Sequencer for the KNN datapath: accepts a test point and a stream of labelled 2-D data points over a valid/ready handshake.
- Computes squared Euclidean distance in a 2-stage pipeline and maintains a sorted list of the K nearest points (insertion per cycle).
- Sits between the CPU-facing register file and the KNN core; software starts a run, waits for done, then reads neighbours by slot.

---
 rtl/knn_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl: K-nearest-neighbour run sequencer with a 2-stage squared-distance pipeline and sorted insert list.
// Optional label majority vote over the final list is built when KNN_LABEL_VOTE_EN is defined.
module knn_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int K       = 4,
    parameter int N_W     = 8,
    parameter int LABEL_W = 8,
    localparam int DIST_W = DATA_W + 3,
    localparam int SEL_W  = (K > 1) ? $clog2(K) : 1,
    localparam int VC_W   = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  test_point,
    input  logic [N_W-1:0]     num_points,
    input  logic               pt_valid,
    input  logic [DATA_W-1:0]  pt_data,
    input  logic [LABEL_W-1:0] pt_label,
    output logic               pt_ready,
    output logic               busy,
    output logic               done,
    input  logic [SEL_W-1:0]   nbr_sel,
    output logic [DIST_W-1:0]  nbr_dist,
    output logic [LABEL_W-1:0] nbr_label,
    output logic [N_W-1:0]     nbr_idx
`ifdef KNN_LABEL_VOTE_EN
    ,
    output logic [LABEL_W-1:0] vote_label,
    output logic [VC_W-1:0]    vote_count
`endif
);

    localparam int HALF = DATA_W / 2;
    localparam int D1_W = HALF + 1;

`ifdef KNN_LABEL_VOTE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_VOTE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_t;
`endif

    state_t              state_r;
    logic [DATA_W-1:0]   tp_r;
    logic [N_W-1:0]      num_r;
    logic [N_W-1:0]      cnt_r;
    logic                start_acc_s;
    logic                accept_s;

    logic                     s1_valid_r;
    logic signed [D1_W-1:0]   s1_dx_r;
    logic signed [D1_W-1:0]   s1_dy_r;
    logic [LABEL_W-1:0]       s1_label_r;
    logic [N_W-1:0]           s1_idx_r;
    logic [D1_W-1:0]          dx_s;
    logic [D1_W-1:0]          dy_s;
    logic signed [DIST_W-1:0] dx_ext_s;
    logic signed [DIST_W-1:0] dy_ext_s;
    logic [DIST_W-1:0]        sq_sum_s;

    logic                s2_valid_r;
    logic [DIST_W-1:0]   s2_dist_r;
    logic [LABEL_W-1:0]  s2_label_r;
    logic [N_W-1:0]      s2_idx_r;

    logic [DIST_W-1:0]   slot_dist_r  [K];
    logic [LABEL_W-1:0]  slot_label_r [K];
    logic [N_W-1:0]      slot_idx_r   [K];
    logic [DIST_W-1:0]   nxt_dist_s   [K];
    logic [LABEL_W-1:0]  nxt_label_s  [K];
    logic [N_W-1:0]      nxt_idx_s    [K];
    logic                prev_lt_s;
    logic                cur_lt_s;
    logic [DIST_W-1:0]   prev_dist_s;
    logic [LABEL_W-1:0]  prev_label_s;
    logic [N_W-1:0]      prev_idx_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign accept_s    = pt_valid && pt_ready;

    // Sign-extended coordinate differences; two's-complement subtraction at D1_W cannot overflow.
    assign dx_s = {pt_data[DATA_W-1], pt_data[DATA_W-1:HALF]} - {tp_r[DATA_W-1], tp_r[DATA_W-1:HALF]};
    assign dy_s = {pt_data[HALF-1], pt_data[HALF-1:0]} - {tp_r[HALF-1], tp_r[HALF-1:0]};
    assign dx_ext_s = DIST_W'(s1_dx_r);
    assign dy_ext_s = DIST_W'(s1_dy_r);
    assign sq_sum_s = dx_ext_s * dx_ext_s + dy_ext_s * dy_ext_s;

    // Run sequencer: handshake counting, drain detection and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            tp_r     <= '0;
            num_r    <= '0;
            cnt_r    <= '0;
            pt_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tp_r  <= test_point;
                        num_r <= num_points;
                        cnt_r <= '0;
                        busy  <= 1'b1;
                        if (num_points == '0) begin
                            state_r  <= ST_DRAIN;
                            pt_ready <= 1'b0;
                        end else begin
                            state_r  <= ST_LOAD;
                            pt_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + N_W'(1);
                        if (cnt_r + N_W'(1) == num_r) begin
                            state_r  <= ST_DRAIN;
                            pt_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // With S1 empty, S2 retires on this edge, so both stages are idle next cycle.
                    if (!s1_valid_r) begin
`ifdef KNN_LABEL_VOTE_EN
                        state_r <= ST_VOTE;
`else
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end
                end
`ifdef KNN_LABEL_VOTE_EN
                ST_VOTE: begin
                    state_r <= ST_DONE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    pt_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Distance pipeline: S1 differences, S2 squared sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_dx_r    <= '0;
            s1_dy_r    <= '0;
            s1_label_r <= '0;
            s1_idx_r   <= '0;
            s2_valid_r <= 1'b0;
            s2_dist_r  <= '0;
            s2_label_r <= '0;
            s2_idx_r   <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_dx_r    <= dx_s;
                s1_dy_r    <= dy_s;
                s1_label_r <= pt_label;
                s1_idx_r   <= cnt_r;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_dist_r  <= sq_sum_s;
                s2_label_r <= s1_label_r;
                s2_idx_r   <= s1_idx_r;
            end
        end
    end

    // Sorted insert: first slot whose distance exceeds the new one takes it; later slots shift up.
    always_comb begin
        prev_lt_s    = 1'b0;
        prev_dist_s  = '0;
        prev_label_s = '0;
        prev_idx_s   = '0;
        cur_lt_s     = 1'b0;
        for (int j = 0; j < K; j++) begin
            cur_lt_s = s2_valid_r && (s2_dist_r < slot_dist_r[j]);
            if (prev_lt_s) begin
                nxt_dist_s[j]  = prev_dist_s;
                nxt_label_s[j] = prev_label_s;
                nxt_idx_s[j]   = prev_idx_s;
            end else if (cur_lt_s) begin
                nxt_dist_s[j]  = s2_dist_r;
                nxt_label_s[j] = s2_label_r;
                nxt_idx_s[j]   = s2_idx_r;
            end else begin
                nxt_dist_s[j]  = slot_dist_r[j];
                nxt_label_s[j] = slot_label_r[j];
                nxt_idx_s[j]   = slot_idx_r[j];
            end
            prev_lt_s    = cur_lt_s;
            prev_dist_s  = slot_dist_r[j];
            prev_label_s = slot_label_r[j];
            prev_idx_s   = slot_idx_r[j];
        end
    end

    // Neighbour list storage; all-ones distance and index mark an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < K; j++) begin
                slot_dist_r[j]  <= '1;
                slot_label_r[j] <= '0;
                slot_idx_r[j]   <= '1;
            end
        end else if (start_acc_s) begin
            for (int j = 0; j < K; j++) begin
                slot_dist_r[j]  <= '1;
                slot_label_r[j] <= '0;
                slot_idx_r[j]   <= '1;
            end
        end else if (s2_valid_r) begin
            for (int j = 0; j < K; j++) begin
                slot_dist_r[j]  <= nxt_dist_s[j];
                slot_label_r[j] <= nxt_label_s[j];
                slot_idx_r[j]   <= nxt_idx_s[j];
            end
        end
    end

    // Slot read port; a select beyond K returns the empty marker.
    always_comb begin
        if (int'(nbr_sel) < K) begin
            nbr_dist  = slot_dist_r[nbr_sel];
            nbr_label = slot_label_r[nbr_sel];
            nbr_idx   = slot_idx_r[nbr_sel];
        end else begin
            nbr_dist  = '1;
            nbr_label = '0;
            nbr_idx   = '1;
        end
    end

`ifdef KNN_LABEL_VOTE_EN
    logic [VC_W-1:0]    tally_s;
    logic [VC_W-1:0]    best_cnt_s;
    logic [LABEL_W-1:0] best_lab_s;

    // Majority label among filled slots; strict compare keeps the lowest slot on ties.
    always_comb begin
        best_cnt_s = '0;
        best_lab_s = '0;
        tally_s    = '0;
        for (int i = 0; i < K; i++) begin
            tally_s = '0;
            for (int j = 0; j < K; j++) begin
                if ((slot_dist_r[i] != '1) && (slot_dist_r[j] != '1) &&
                    (slot_label_r[j] == slot_label_r[i])) begin
                    tally_s = tally_s + VC_W'(1);
                end else begin
                    tally_s = tally_s;
                end
            end
            if (tally_s > best_cnt_s) begin
                best_cnt_s = tally_s;
                best_lab_s = slot_label_r[i];
            end else begin
                best_cnt_s = best_cnt_s;
            end
        end
    end

    // Vote result register, captured in VOTE and held until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_label <= '0;
            vote_count <= '0;
        end else if (start_acc_s) begin
            vote_label <= '0;
            vote_count <= '0;
        end else if (state_r == ST_VOTE) begin
            vote_label <= best_lab_s;
            vote_count <= best_cnt_s;
        end
    end
`endif

endmodule
